// File: rtl/crossy_pkg.sv
// Shared constants for the Crossy Road display path.
//  - Colour constants for every scene element, as 24-bit {R,G,B}.
//  - PLAYER_COLOR: one sprite colour per player slot (up to 4 players).
//  - TILE_DEFAULT: default tile size in pixels.
//  - in_grid(): tests a 4-bit tile coordinate pair against the grid size.
package crossy_pkg;

  localparam int TILE_DEFAULT = 40;

  localparam logic [23:0] COLOR_BG    = 24'hAACCFF;
  localparam logic [23:0] COLOR_ROAD  = 24'hA9A9A9;
  localparam logic [23:0] COLOR_TRACK = 24'h505050;
  localparam logic [23:0] COLOR_TREE  = 24'h228B22;
  localparam logic [23:0] COLOR_CAR   = 24'hCC2222;
  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;

  // Index 0 is the leftmost entry.
  localparam logic [0:3][23:0] PLAYER_COLOR = '{24'hFFD700, 24'h00B0FF, 24'hFF00FF, 24'hFF8000};

  // A sprite whose coordinates fall outside the grid is neither drawn nor collides.
  function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y,
                                   input int gw, input int gh);
    return (int'(x) < gw) && (int'(y) < gh);
  endfunction

endpackage

// File: rtl/car_lane_ctr.sv
// Wrapping column counter for one car.
//  clk    in   system clock
//  rst    in   async reset, active-high; loads X0
//  step_i in   advance one column this clk
//  pos_o  out  registered current column
module car_lane_ctr #(
  parameter int         GRID_W = 16,
  parameter logic [3:0] X0     = 4'd0,
  parameter logic       DIR    = 1'b0   // 0 = +x, 1 = -x
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  output logic [3:0] pos_o
);

  logic [3:0] pos_q, pos_d;

  // The column wraps at both edges of the grid.
  always_comb begin
    pos_d = pos_q;
    if (step_i) begin
      if (DIR == 1'b0) begin
        pos_d = (pos_q == 4'(GRID_W - 1)) ? 4'd0 : pos_q + 4'd1;
      end else begin
        pos_d = (pos_q == 4'd0) ? 4'(GRID_W - 1) : pos_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_q <= X0;
    else     pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/tile_scene_renderer.sv
// Tile-grid pixel renderer: scenery rows, moving cars and player sprites.
//  clk, rst         clock, async active-high reset
//  active_pixels    1 = visible area; x_pixel/y_pixel current pixel
//  frame_start      one-clk pulse per frame; run enables car movement
//  player_x/_y      packed 4-bit player tile coordinates, player 0 in [3:0]
//  clr_collision    clears the sticky collision flags (a same-clk set wins)
//  vga_color        registered colour, one clk after the pixel coordinates
//  collision        sticky per-player hit flags
//  car_x            packed current car columns, same packing as CAR_X0
module tile_scene_renderer
  import crossy_pkg::*;
#(
  parameter int                    TILE        = TILE_DEFAULT,
  parameter int                    GRID_W      = 16,
  parameter int                    GRID_H      = 12,
  parameter int                    NUM_PLAYERS = 2,
  parameter int                    NUM_CARS    = 4,
  parameter logic [4*NUM_CARS-1:0] CAR_ROW     = {4'd2, 4'd3, 4'd9, 4'd10},
  parameter logic [4*NUM_CARS-1:0] CAR_X0      = {4'd0, 4'd5, 4'd10, 4'd15},
  parameter logic [NUM_CARS-1:0]   CAR_DIR     = 4'b0101,
  parameter int                    CAR_PERIOD  = 8,
  parameter logic [GRID_H-1:0]     STREET_MASK = 12'h60C,
  parameter logic [GRID_H-1:0]     TRACK_MASK  = 12'h040,
  parameter int                    TREE_ROW    = 1,
  parameter logic [GRID_W-1:0]     TREE_MASK   = 16'hB55B
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     active_pixels,
  input  logic [9:0]               x_pixel,
  input  logic [9:0]               y_pixel,
  input  logic                     frame_start,
  input  logic                     run,
  input  logic [4*NUM_PLAYERS-1:0] player_x,
  input  logic [4*NUM_PLAYERS-1:0] player_y,
  input  logic                     clr_collision,
  output logic [23:0]              vga_color,
  output logic [NUM_PLAYERS-1:0]   collision,
  output logic [4*NUM_CARS-1:0]    car_x
);

  localparam int         CW     = (CAR_PERIOD > 1) ? $clog2(CAR_PERIOD) : 1;
  localparam logic [9:0] TILE_W = 10'(TILE);

  logic [CW-1:0]          frame_cnt_q, frame_cnt_d;
  logic                   step_s;
  logic [NUM_PLAYERS-1:0] collision_q, collision_d, hit_s;
  logic [23:0]            color_q, color_d;
  logic [9:0]             gx_s, gy_s;
  logic                   player_on_s, car_on_s, track_s, street_s, tree_s;
  logic [23:0]            player_col_s;

  // Frame counter; a step is issued on the pulse that wraps it.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    step_s      = 1'b0;
    if (frame_start && run) begin
      if (frame_cnt_q == CW'(CAR_PERIOD - 1)) begin
        frame_cnt_d = '0;
        step_s      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    car_lane_ctr #(
      .GRID_W (GRID_W),
      .X0     (CAR_X0[4*i +: 4]),
      .DIR    (CAR_DIR[i])
    ) u_car (
      .clk    (clk),
      .rst    (rst),
      .step_i (step_s),
      .pos_o  (car_x[4*i +: 4])
    );
  end

  // Collision test uses car_x before this clk's step is applied.
  always_comb begin
    hit_s = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int c = 0; c < NUM_CARS; c++) begin
        if (in_grid(player_x[4*p +: 4], player_y[4*p +: 4], GRID_W, GRID_H) &&
            in_grid(car_x[4*c +: 4], CAR_ROW[4*c +: 4], GRID_W, GRID_H) &&
            (player_x[4*p +: 4] == car_x[4*c +: 4]) &&
            (player_y[4*p +: 4] == CAR_ROW[4*c +: 4])) begin
          hit_s[p] = 1'b1;
        end
      end
    end
    collision_d = clr_collision ? '0 : collision_q;
    if (frame_start) collision_d = collision_d | hit_s;
  end

  // Pixel -> tile decode; parked at tile 0 outside the visible area.
  always_comb begin
    gx_s = 10'd0;
    gy_s = 10'd0;
    if (active_pixels) begin
      gx_s = x_pixel / TILE_W;
      gy_s = y_pixel / TILE_W;
    end
  end

  // Layer hits for the current tile; players loop downward so player 0 wins.
  always_comb begin
    player_on_s  = 1'b0;
    player_col_s = COLOR_WHITE;
    car_on_s     = 1'b0;
    track_s      = 1'b0;
    street_s     = 1'b0;
    tree_s       = 1'b0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (in_grid(player_x[4*p +: 4], player_y[4*p +: 4], GRID_W, GRID_H) &&
          (gx_s == {6'd0, player_x[4*p +: 4]}) && (gy_s == {6'd0, player_y[4*p +: 4]})) begin
        player_on_s  = 1'b1;
        player_col_s = PLAYER_COLOR[2'(p)];
      end
    end
    for (int c = 0; c < NUM_CARS; c++) begin
      if (in_grid(car_x[4*c +: 4], CAR_ROW[4*c +: 4], GRID_W, GRID_H) &&
          (gx_s == {6'd0, car_x[4*c +: 4]}) && (gy_s == {6'd0, CAR_ROW[4*c +: 4]})) begin
        car_on_s = 1'b1;
      end
    end
    for (int r = 0; r < GRID_H; r++) begin
      if (gy_s == 10'(r)) begin
        track_s  = TRACK_MASK[r];
        street_s = STREET_MASK[r];
      end
    end
    for (int x = 0; x < GRID_W; x++) begin
      if ((gy_s == 10'(TREE_ROW)) && (gx_s == 10'(x))) tree_s = TREE_MASK[x];
    end
  end

  // Priority colour mux.
  always_comb begin
    color_d = COLOR_BG;
    if (!active_pixels)   color_d = COLOR_WHITE;
    else if (player_on_s) color_d = player_col_s;
    else if (car_on_s)    color_d = COLOR_CAR;
    else if (track_s)     color_d = COLOR_TRACK;
    else if (street_s)    color_d = COLOR_ROAD;
    else if (tree_s)      color_d = COLOR_TREE;
    else                  color_d = COLOR_BG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      collision_q <= '0;
      color_q     <= COLOR_BG;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      collision_q <= collision_d;
      color_q     <= color_d;
    end
  end

  assign vga_color = color_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_tile_scene_renderer.sv
module tb_tile_scene_renderer;

  localparam int NP = 2;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        active_pixels = 1'b1;
  logic [9:0]  x_pixel = 10'd0;
  logic [9:0]  y_pixel = 10'd0;
  logic        frame_start = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  player_x = 8'hFF;
  logic [7:0]  player_y = 8'hDD;
  logic        clr_collision = 1'b0;
  logic [23:0] vga_color;
  logic [1:0]  collision;
  logic [15:0] car_x;

  tile_scene_renderer dut (
    .clk           (clk),
    .rst           (rst),
    .active_pixels (active_pixels),
    .x_pixel       (x_pixel),
    .y_pixel       (y_pixel),
    .frame_start   (frame_start),
    .run           (run),
    .player_x      (player_x),
    .player_y      (player_y),
    .clr_collision (clr_collision),
    .vga_color     (vga_color),
    .collision     (collision),
    .car_x         (car_x)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [23:0] color;
    logic [1:0]  coll;
    logic [15:0] cars;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: car slot i is nibble i of the packed parameters.
  int          row_of[NC] = '{10, 9, 3, 2};
  int          x0_of[NC]  = '{15, 10, 5, 0};
  int          dir_of[NC] = '{1, 0, 1, 0};
  logic [23:0] pcol[4]    = '{24'hFFD700, 24'h00B0FF, 24'hFF00FF, 24'hFF8000};
  int          m_car[NC];
  int          m_fcnt;
  logic [1:0]  m_coll;

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [15:0] pack_cars();
    logic [15:0] r;
    for (int c = 0; c < NC; c++) r[4*c +: 4] = 4'(m_car[c]);
    return r;
  endfunction

  function automatic bit car_at(int tx, int ty);
    for (int c = 0; c < NC; c++)
      if (m_car[c] == tx && row_of[c] == ty) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit on_grid(int tx, int ty);
    return (tx < 16) && (ty < 12);
  endfunction

  function automatic logic [23:0] ref_color(int x, int y, bit act);
    int tx, ty;
    if (!act) return 24'hFFFFFF;
    tx = x / 40;
    ty = y / 40;
    for (int p = 0; p < NP; p++) begin
      int px, py;
      px = int'(player_x[4*p +: 4]);
      py = int'(player_y[4*p +: 4]);
      if (on_grid(px, py) && px == tx && py == ty) return pcol[p];
    end
    if (car_at(tx, ty)) return 24'hCC2222;
    if (ty == 6) return 24'h505050;
    if (ty inside {2, 3, 9, 10}) return 24'hA9A9A9;
    if (ty == 1 && tx inside {0, 1, 3, 4, 6, 8, 10, 12, 13, 15}) return 24'h228B22;
    return 24'hAACCFF;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) m_car[c] = x0_of[c];
    m_fcnt = 0;
    m_coll = 2'b00;
  endtask

  // One clock of stimulus; the model predicts the state after the next posedge.
  task automatic tick(input logic [9:0] x, input logic [9:0] y, input bit act, input bit fs,
                      input bit rn, input bit clr, input logic [7:0] px, input logic [7:0] py);
    exp_t e;
    @(negedge clk);
    x_pixel = x; y_pixel = y; active_pixels = act;
    frame_start = fs; run = rn; clr_collision = clr;
    player_x = px; player_y = py;
    e.color = ref_color(int'(x), int'(y), act);
    if (clr) m_coll = 2'b00;
    if (fs) begin
      for (int p = 0; p < NP; p++) begin
        int qx, qy;
        qx = int'(px[4*p +: 4]);
        qy = int'(py[4*p +: 4]);
        if (on_grid(qx, qy) && car_at(qx, qy)) m_coll[p] = 1'b1;
      end
    end
    if (fs && rn) begin
      m_fcnt++;
      if (m_fcnt == 8) begin
        m_fcnt = 0;
        for (int c = 0; c < NC; c++)
          m_car[c] = (dir_of[c] == 0) ? (m_car[c] + 1) % 16 : (m_car[c] + 15) % 16;
      end
    end
    e.coll = m_coll;
    e.cars = pack_cars();
    exp_q.push_back(e);
  endtask

  task automatic pulses(input int n, input bit rn);
    for (int i = 0; i < n; i++) begin
      tick(10'd0, 10'd0, 1'b1, 1'b1, rn, 1'b0, 8'hFF, 8'hDD);
      tick(10'd0, 10'd0, 1'b1, 1'b0, rn, 1'b0, 8'hFF, 8'hDD);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_start = 1'b0; clr_collision = 1'b0; run = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_color", vga_color, 24'hAACCFF);
    chk("rst_collision", {22'd0, collision}, 24'd0);
    chk("rst_car_x", {8'd0, car_x}, {8'd0, 16'h05AF});
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every clk the DUT presents a new output; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("color", vga_color, e.color);
        chk("collision", {22'd0, collision}, {22'd0, e.coll});
        chk("car_x", {8'd0, car_x}, {8'd0, e.cars});
      end
    end
  end

  initial begin
    logic [7:0] px, py;
    logic [9:0] x, y;
    int         sel, c;

    #2 rst = 1'b1;
    #2;
    chk("rst0_color", vga_color, 24'hAACCFF);
    chk("rst0_collision", {22'd0, collision}, 24'd0);
    chk("rst0_car_x", {8'd0, car_x}, {8'd0, 16'h05AF});
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Scenery
    tick(10'd100, 10'd90, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hDD);
    after_edge(); chk("scenery_road", vga_color, 24'hA9A9A9);
    tick(10'd50, 10'd45, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hDD);
    after_edge(); chk("scenery_tree", vga_color, 24'h228B22);
    tick(10'd300, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hDD);
    after_edge(); chk("inactive_white", vga_color, 24'hFFFFFF);
    tick(10'd250, 10'd260, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hDD);
    after_edge(); chk("track_row", vga_color, 24'h505050);

    // Movement: one step per 8 pulses, then wraps after 6 steps
    pulses(8, 1'b1);
    after_edge(); chk("move_1step", {8'd0, car_x}, {8'd0, 16'h14BE});
    pulses(40, 1'b1);
    after_edge(); chk("move_wrap", {8'd0, car_x}, {8'd0, 16'h6F09});

    // Freeze with the frame counter mid-count
    pulses(3, 1'b1);
    pulses(20, 1'b0);
    after_edge(); chk("freeze", {8'd0, car_x}, {8'd0, 16'h6F09});
    pulses(4, 1'b1);
    after_edge(); chk("freeze_cnt_held", {8'd0, car_x}, {8'd0, 16'h6F09});
    pulses(1, 1'b1);
    after_edge(); chk("resume_step", {8'd0, car_x}, {8'd0, 16'h7E18});

    // Collision: row-2 car now at column 7
    tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF7, 8'hD2);
    after_edge(); chk("coll_set", {22'd0, collision}, 24'd1);
    tick(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hDD);
    after_edge(); chk("coll_clear", {22'd0, collision}, 24'd0);
    tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF7, 8'hD2);
    after_edge(); chk("coll_set_wins", {22'd0, collision}, 24'd1);

    // Priority: both players on the row-9 car at column 1
    tick(10'd60, 10'd365, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h99);
    after_edge(); chk("prio_player0", vga_color, 24'hFFD700);
    tick(10'd290, 10'd85, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hDD);
    after_edge(); chk("prio_car", vga_color, 24'hCC2222);
    tick(10'd605, 10'd525, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hDD);
    after_edge(); chk("offgrid_player", vga_color, 24'hAACCFF);

    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          c = $urandom_range(0, NC - 1);
          px[4*p +: 4] = 4'(m_car[c]);
          py[4*p +: 4] = 4'(row_of[c]);
        end else begin
          px[4*p +: 4] = 4'($urandom_range(0, 15));
          py[4*p +: 4] = 4'($urandom_range(0, 13));
        end
      end
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        c = $urandom_range(0, NC - 1);
        x = 10'(m_car[c] * 40 + $urandom_range(0, 39));
        y = 10'(row_of[c] * 40 + $urandom_range(0, 39));
      end else if (sel == 1) begin
        x = 10'(int'(px[3:0]) * 40 + $urandom_range(0, 39));
        y = 10'(int'(py[3:0]) * 40 + $urandom_range(0, 39));
      end else if (sel == 2) begin
        x = 10'($urandom_range(0, 639));
        y = 10'($urandom_range(0, 479));
      end else begin
        x = 10'($urandom_range(0, 1023));
        y = 10'($urandom_range(0, 1023));
      end
      tick(x, y, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), px, py);
      if (n == 1500) do_reset();
    end

    after_edge();
    chk("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
